plate_char_scan_sched: RTL and testbench

- Sequences the 3x3 digit feature scanner across the character boxes of one licence plate, one character per video frame.
- Holds a small table of character bounding boxes written by upstream segmentation.
- For each character, drives the scanner's char_up/char_down/char_left/char_right, switching them only while i_vs is low.
- Waits the configured number of frames, captures the scanner's digit code, and publishes all digits atomically as one result vector.

---
 rtl/plate_sched_pkg.sv | 30 +++
 rtl/plate_char_box_table.sv | 34 +++
 rtl/plate_char_scan_sched.sv | 198 +++++++++++++++++++
 tb/tb_plate_char_scan_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plate_sched_pkg.sv
// Shared types and constants for the licence-plate character scan sequencer.
// The box struct packs the edges in the order up, down, left, right.
package plate_sched_pkg;

  localparam int          COORD_W       = 12;
  localparam int          IDX_W         = 3;
  localparam logic [3:0]  DIGIT_INVALID = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ARM,
    HOLD,
    CAPTURE,
    DONE
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] up;
    logic [COORD_W-1:0] down;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
  } box_t;

  // A degenerate or inverted box cannot hold a character.
  function automatic logic box_valid(box_t b);
    return (b.left < b.right) && (b.up < b.down);
  endfunction

endpackage

// File: rtl/plate_char_box_table.sv
// Character bounding-box table: one write port that is locked while a scan runs,
// and a combinational read of the entry being scanned plus its validity flag.
module plate_char_box_table
  import plate_sched_pkg::*;
#(
  parameter int MAX_CHARS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             busy,
  input  logic [IDX_W-1:0] wr_idx,
  input  box_t             wr_box,
  input  logic [IDX_W-1:0] rd_idx,
  output box_t             rd_box,
  output logic             rd_valid
);

  box_t entries [MAX_CHARS];

  // NOTE: the table is small and must read back as all-zero boxes after reset,
  // so every entry is reset explicitly rather than left to power-up contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHARS; i++) entries[i] <= '0;
    end else if (wr_en && !busy && (int'(wr_idx) < MAX_CHARS)) begin
      entries[wr_idx] <= wr_box;
    end
  end

  assign rd_box   = (int'(rd_idx) < MAX_CHARS) ? entries[rd_idx] : '0;
  assign rd_valid = box_valid(rd_box);

endmodule

// File: rtl/plate_char_scan_sched.sv
// Steps the 3x3 digit scanner through the plate's character boxes, one per frame,
// and publishes all captured digits together when the last character retires.
module plate_char_scan_sched
  import plate_sched_pkg::*;
#(
  parameter int MAX_CHARS     = 8,
  parameter int SETTLE_FRAMES = 1,
  parameter int FRAME_TIMEOUT = 2000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_vs,
  input  logic                   start,
  input  logic [3:0]             char_cnt,
  input  logic                   box_wr_en,
  input  logic [IDX_W-1:0]       box_wr_idx,
  input  logic [COORD_W-1:0]     box_wr_up,
  input  logic [COORD_W-1:0]     box_wr_down,
  input  logic [COORD_W-1:0]     box_wr_left,
  input  logic [COORD_W-1:0]     box_wr_right,
  input  logic [3:0]             i_digit,
  output logic [COORD_W-1:0]     char_up,
  output logic [COORD_W-1:0]     char_down,
  output logic [COORD_W-1:0]     char_left,
  output logic [COORD_W-1:0]     char_right,
  output logic [IDX_W-1:0]       o_cur_idx,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*MAX_CHARS-1:0] o_result,
  output logic                   o_timeout
);

  localparam int CNT_W = IDX_W + 1;
  localparam int WD_W  = $clog2(FRAME_TIMEOUT + 1);
  localparam int RES_W = 4 * MAX_CHARS;

  state_t             state_q, state_d;
  logic               vs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [2:0]         frame_q, frame_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [RES_W-1:0]   work_q, work_d;
  logic [RES_W-1:0]   result_q, result_d;
  box_t               box_q, box_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  box_t               rd_box;
  logic               rd_valid;
  logic               vs_rise, vs_fall, vs_edge;
  logic               wdog_expired;
  logic [CNT_W-1:0]   start_cnt;
  logic [CNT_W-1:0]   idx_inc;
  logic               retire;
  logic [3:0]         retire_digit;

  plate_char_box_table #(.MAX_CHARS(MAX_CHARS)) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (box_wr_en),
    .busy     (busy_q),
    .wr_idx   (box_wr_idx),
    .wr_box   (box_t'{up: box_wr_up, down: box_wr_down, left: box_wr_left, right: box_wr_right}),
    .rd_idx   (idx_q[IDX_W-1:0]),
    .rd_box   (rd_box),
    .rd_valid (rd_valid)
  );

  assign vs_rise      = i_vs & ~vs_d;
  assign vs_fall      = ~i_vs & vs_d;
  assign vs_edge      = vs_rise | vs_fall;
  assign wdog_expired = (wdog_q == WD_W'(FRAME_TIMEOUT - 1));
  assign start_cnt    = (char_cnt > CNT_W'(MAX_CHARS)) ? CNT_W'(MAX_CHARS) : char_cnt;
  assign idx_inc      = idx_q + 1'b1;

  // NOTE: every variable gets its hold value first so no path through the case
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    wdog_d       = wdog_q;
    work_d       = work_q;
    result_d     = result_q;
    box_d        = box_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    retire       = 1'b0;
    retire_digit = DIGIT_INVALID;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = start_cnt;
          idx_d     = '0;
          work_d    = '1;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          state_d   = (start_cnt == '0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        if (!rd_valid) begin
          retire = 1'b1;
        end else if (!i_vs) begin
          box_d   = rd_box;
          wdog_d  = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        wdog_d = vs_edge ? '0 : wdog_q + 1'b1;
        if (vs_rise) begin
          frame_d = '0;
          state_d = HOLD;
        end else if (!vs_edge && wdog_expired) begin
          timeout_d = 1'b1;
          retire    = 1'b1;
        end
      end
      HOLD: begin
        wdog_d = vs_edge ? '0 : wdog_q + 1'b1;
        if (vs_fall) begin
          frame_d = frame_q + 1'b1;
          if (frame_q + 3'd1 == 3'(SETTLE_FRAMES)) state_d = CAPTURE;
        end else if (!vs_edge && wdog_expired) begin
          timeout_d = 1'b1;
          retire    = 1'b1;
        end
      end
      CAPTURE: begin
        retire       = 1'b1;
        retire_digit = i_digit;
      end
      DONE: begin
        result_d = work_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Skipped, aborted and captured characters all retire the same way.
    if (retire) begin
      work_d[4*int'(idx_q[IDX_W-1:0]) +: 4] = retire_digit;
      idx_d   = idx_inc;
      state_d = (idx_inc == cnt_q) ? DONE : SELECT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vs_d      <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      wdog_q    <= '0;
      work_q    <= '1;
      result_q  <= '1;
      box_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_d      <= i_vs;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      wdog_q    <= wdog_d;
      work_q    <= work_d;
      result_q  <= result_d;
      box_q     <= box_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign char_up    = box_q.up;
  assign char_down  = box_q.down;
  assign char_left  = box_q.left;
  assign char_right = box_q.right;
  assign o_cur_idx  = busy_q ? idx_q[IDX_W-1:0] : '0;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_plate_char_scan_sched.sv
// Self-checking bench: table-driven plate scans with a result scoreboard, plus
// hand-written sequences for mid-frame start, watchdog, busy lockout and reset.
module tb_plate_char_scan_sched;
  import plate_sched_pkg::*;

  localparam int MAXC   = 8;
  localparam int SETTLE = 1;
  localparam int TMO    = 50;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_vs;
  logic                 start;
  logic [3:0]           char_cnt;
  logic                 box_wr_en;
  logic [IDX_W-1:0]     box_wr_idx;
  logic [COORD_W-1:0]   box_wr_up, box_wr_down, box_wr_left, box_wr_right;
  logic [3:0]           i_digit;
  logic [COORD_W-1:0]   char_up, char_down, char_left, char_right;
  logic [IDX_W-1:0]     o_cur_idx;
  logic                 o_busy, o_done, o_timeout;
  logic [4*MAXC-1:0]    o_result;

  plate_char_scan_sched #(
    .MAX_CHARS(MAXC), .SETTLE_FRAMES(SETTLE), .FRAME_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .start(start), .char_cnt(char_cnt),
    .box_wr_en(box_wr_en), .box_wr_idx(box_wr_idx),
    .box_wr_up(box_wr_up), .box_wr_down(box_wr_down),
    .box_wr_left(box_wr_left), .box_wr_right(box_wr_right),
    .i_digit(i_digit),
    .char_up(char_up), .char_down(char_down), .char_left(char_left), .char_right(char_right),
    .o_cur_idx(o_cur_idx), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of published results, popped on every o_done pulse.
  typedef struct {
    logic [31:0] result;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(o_done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(o_result), 64'(mon_e.result));
        check("timeout_flag", 64'(o_timeout), 64'(mon_e.tmo));
      end
    end
  end

  function automatic box_t good_box(input int k);
    box_t b;
    b.up    = COORD_W'(10 + k);
    b.down  = COORD_W'(60 + k);
    b.left  = COORD_W'(100 + 8 * k);
    b.right = COORD_W'(300 + 8 * k);
    return b;
  endfunction

  // Odd entries are zero-width (left == right), even entries inverted vertically.
  function automatic box_t bad_box(input int k);
    box_t b;
    if (k % 2 == 1) begin
      b.up = 12'd10; b.down = 12'd60; b.left = 12'd100; b.right = 12'd100;
    end else begin
      b.up = 12'd50; b.down = 12'd40; b.left = 12'd100; b.right = 12'd300;
    end
    return b;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_box(input int k, input box_t b);
    box_wr_en    = 1'b1;
    box_wr_idx   = IDX_W'(k);
    box_wr_up    = b.up;
    box_wr_down  = b.down;
    box_wr_left  = b.left;
    box_wr_right = b.right;
    step(1);
    box_wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] cnt);
    char_cnt = cnt;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  // One video frame: 20 cycles active, 10 blanking; the box is checked mid-frame.
  task automatic frame(input logic [3:0] d, input box_t b, input int k);
    i_digit = d;
    i_vs    = 1'b1;
    step(10);
    check("char_box", 64'({char_up, char_down, char_left, char_right}), 64'(b));
    check("cur_idx", 64'(o_cur_idx), 64'(k));
    step(10);
    i_vs = 1'b0;
    step(10);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      step(1);
      n++;
    end
    check(name, 64'(done_cnt), 64'(target));
  endtask

  typedef struct {
    logic [3:0]  cnt;
    logic [7:0]  valid;
    logic [31:0] digits;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int   fidx;
    int   ncnt;
    int   target;
    int   n;
    box_t last_box;

    vecs[0] = '{cnt: 4'd3,  valid: 8'hFF, digits: 32'h0000_0917, exp_result: 32'hFFFF_F917};
    vecs[1] = '{cnt: 4'd3,  valid: 8'hFD, digits: 32'h0000_0064, exp_result: 32'hFFFF_F6F4};
    vecs[2] = '{cnt: 4'd0,  valid: 8'hFF, digits: 32'h0000_0000, exp_result: 32'hFFFF_FFFF};
    vecs[3] = '{cnt: 4'd8,  valid: 8'hFF, digits: 32'h7654_3210, exp_result: 32'h7654_3210};
    vecs[4] = '{cnt: 4'd12, valid: 8'hFF, digits: 32'h2EDC_BA98, exp_result: 32'h2EDC_BA98};
    vecs[5] = '{cnt: 4'd2,  valid: 8'hFE, digits: 32'h0000_0005, exp_result: 32'hFFFF_FF5F};
    vecs[6] = '{cnt: 4'd4,  valid: 8'h0A, digits: 32'h0000_00C3, exp_result: 32'hFFFF_CF3F};

    rst_n = 1'b0; i_vs = 1'b0; start = 1'b0; char_cnt = '0; box_wr_en = 1'b0;
    box_wr_idx = '0; box_wr_up = '0; box_wr_down = '0; box_wr_left = '0; box_wr_right = '0;
    i_digit = '0;
    last_box = '0;
    step(3);
    check("rst_result", 64'(o_result), 64'hFFFF_FFFF);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_timeout", 64'(o_timeout), 64'd0);
    check("rst_char", 64'({char_up, char_down, char_left, char_right}), 64'd0);
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < MAXC; k++) write_box(k, vecs[i].valid[k] ? good_box(k) : bad_box(k));
      sb.push_back('{result: vecs[i].exp_result, tmo: 1'b0});
      target = done_cnt + 1;
      do_start(vecs[i].cnt);
      check("busy_after_start", 64'(o_busy), 64'd1);
      step(3);
      fidx = 0;
      ncnt = (int'(vecs[i].cnt) > MAXC) ? MAXC : int'(vecs[i].cnt);
      for (int k = 0; k < ncnt; k++) begin
        if (vecs[i].valid[k]) begin
          frame(vecs[i].digits[4*fidx +: 4], good_box(k), k);
          last_box = good_box(k);
          fidx++;
        end
      end
      wait_done(target, "vec_done");
      check("busy_after_done", 64'(o_busy), 64'd0);
    end

    // Start during an active frame: box must not change until blanking.
    write_box(0, good_box(0));
    i_vs = 1'b1;
    step(5);
    i_digit = 4'hE;
    sb.push_back('{result: 32'hFFFF_FFF3, tmo: 1'b0});
    target = done_cnt + 1;
    do_start(4'd1);
    step(8);
    check("midframe_box_held", 64'({char_up, char_down, char_left, char_right}), 64'(last_box));
    i_vs = 1'b0;
    step(3);
    check("midframe_box_loaded", 64'({char_up, char_down, char_left, char_right}), 64'(good_box(0)));
    check("midframe_no_early_done", 64'(done_cnt), 64'(target - 1));
    step(7);
    frame(4'h3, good_box(0), 0);
    wait_done(target, "midframe_done");

    // Watchdog abort with vs stuck low.
    sb.push_back('{result: 32'hFFFF_FFFF, tmo: 1'b1});
    target = done_cnt + 1;
    do_start(4'd1);
    n = 0;
    while (done_cnt < target && n < 300) begin
      step(1);
      n++;
    end
    check("timeout_latency_ok", 64'((n >= 48 && n <= 56) ? 1 : 0), 64'd1);
    step(20);
    check("timeout_sticky", 64'(o_timeout), 64'd1);

    // Table write and second start while busy are both ignored.
    sb.push_back('{result: 32'hFFFF_FFFA, tmo: 1'b0});
    target = done_cnt + 1;
    do_start(4'd1);
    check("timeout_cleared", 64'(o_timeout), 64'd0);
    write_box(0, '{up: 12'd1, down: 12'd2000, left: 12'd999, right: 12'd1000});
    do_start(4'd3);
    step(2);
    frame(4'hA, good_box(0), 0);
    wait_done(target, "busy_lock_done");
    step(60);
    check("single_done", 64'(done_cnt), 64'(target));

    sb.push_back('{result: 32'hFFFF_FFF8, tmo: 1'b0});
    target = done_cnt + 1;
    do_start(4'd1);
    step(3);
    frame(4'h8, good_box(0), 0);
    wait_done(target, "table_intact_done");

    // Reset while holding a frame.
    target = done_cnt;
    do_start(4'd2);
    step(3);
    i_vs = 1'b1;
    step(5);
    rst_n = 1'b0;
    step(1);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_done", 64'(o_done), 64'd0);
    check("midrst_result", 64'(o_result), 64'hFFFF_FFFF);
    check("midrst_char", 64'({char_up, char_down, char_left, char_right}), 64'd0);
    check("midrst_idx", 64'(o_cur_idx), 64'd0);
    step(2);
    i_vs  = 1'b0;
    rst_n = 1'b1;
    step(5);
    check("midrst_no_done", 64'(done_cnt), 64'(target));

    // Cleared table: every box is empty, so the character is skipped.
    sb.push_back('{result: 32'hFFFF_FFFF, tmo: 1'b0});
    target = done_cnt + 1;
    do_start(4'd1);
    wait_done(target, "cleared_table_done");

    write_box(0, good_box(0));
    sb.push_back('{result: 32'hFFFF_FFF6, tmo: 1'b0});
    target = done_cnt + 1;
    do_start(4'd1);
    step(3);
    frame(4'h6, good_box(0), 0);
    wait_done(target, "post_reset_done");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
